plic_lite: RTL and testbench
============================

// Module: plic_lite
// PURPOSE
//  Platform-level interrupt arbiter that shares the single machine external interrupt (eip/eip_reply) of
//  the privilege CSR unit between NSRC peripheral sources. Per-source gateway, enable, priority and a
//  global threshold; highest-priority request drives eip. Software claims/completes over the MMIO bus.
// PARAMETERS
//  NSRC    8  number of sources, 1..16; irq_src[i] is source ID i+1, ID 0 = "none"
//  PRIO_W  3  priority width; priority 0 = never interrupts
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, synchronous, active-high
//  irq_src   in   NSRC   level requests, already synchronous to clk
//  a         in   5      word register index
//  d         in   32     write data
//  we        in   1      write strobe, one cycle per write
//  rd        in   1      read strobe; qualifies claim side effect
//  spo       out  32     combinational read data for index a
//  eip       out  1      external interrupt to privilege unit (registered)
//  eip_reply in   1      one-cycle acknowledge from privilege unit when it issues the interrupt
// BEHAVIOUR
//  Map: 0x00 PENDING RO | 0x01 ENABLE RW [NSRC-1:0] | 0x02 THRESHOLD RW [PRIO_W-1:0]
//       0x03 CLAIM (read with rd) / COMPLETE (write ID) | 0x10+i PRIORITY of ID i+1, RW [PRIO_W-1:0]
//  Unmapped index reads 0, writes ignored; writes truncate to field width, reads zero-extend.
//  Reset: pending, in_service, enable, threshold, priorities = 0; eip = 0; FSM IDLE; best_id = 0.
//  Gateway per source: irq_src high & !pending & !in_service -> pending set next edge.
//   Claim of ID: pending cleared, in_service set. Complete of ID: in_service cleared; if still high, re-pends next edge.
//   Complete with ID 0, ID > NSRC or ID not in service: ignored.
//  Arbiter: candidates = pending & enable & prio>0; winner = highest prio, tie -> lowest ID.
//   Registered each cycle into best_id/best_prio; best_valid = best_id!=0 & best_prio > threshold.
//  Latency: irq_src high before edge E0 -> pending after E0 -> best after E1 -> eip high after E2.
//  CLAIM read returns best_id (0 if !best_valid); side effect only on edge with rd & a==0x03 & best_valid.
//  Claim + gateway set/complete on other IDs in same cycle: all applied independently.
//  eip FSM (2 bits):
//   IDLE: eip=0; best_valid -> ASSERT.
//   ASSERT: eip=1; eip_reply -> WAIT_CLAIM; else !best_valid (enable/threshold change) -> IDLE.
//   WAIT_CLAIM: eip=0 (masks re-issue while handler runs); valid claim read -> IDLE;
//     !best_valid -> IDLE. eip_reply outside ASSERT ignored.
//  Claim while in ASSERT (polling software): -> IDLE; eip deasserts next edge.
//  Reset mid-operation: all state to reset values next edge, eip low after that edge.
// STRUCTURE
//  Package plic_lite_pkg: register index localparams, ID_W = $clog2(NSRC+1), FSM state encodings.
//  Sub-module plic_gateway (one per source: pending/in_service flops, set/claim/complete inputs),
//  generated NSRC times; arbiter compare tree and FSM stay in plic_lite.
// TESTING
//  1 ID3 prio 5, enable, thr 0, raise irq_src[2] -> eip high 3 cycles later; CLAIM read = 3, PENDING bit2 = 0.
//  2 ID2 prio 4, ID5 prio 4, ID6 prio 2, all pending -> claim 2, then 5 after completing 2, then 6.
//  3 ID1 prio 3, threshold 3 -> eip stays 0; threshold 2 -> eip rises 2 cycles after write.
//  4 eip_reply pulse in ASSERT -> eip 0 next edge and stays 0 until claim; claim -> IDLE; second pending re-asserts eip.
//  5 Source held high after claim -> no re-pend; write COMPLETE=ID -> pending again next edge; complete of 0/9/non-service ID -> no change.
//  6 Assert rst while eip=1, in_service set -> all registers 0, eip 0, CLAIM reads 0.

Source files
------------

// File: rtl/plic_lite_pkg.sv
// Shared definitions for the platform interrupt arbiter: register map, ID sizing, eip FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package plic_lite_pkg;

  // MMIO word indices
  localparam logic [4:0] REG_PENDING   = 5'h00;
  localparam logic [4:0] REG_ENABLE    = 5'h01;
  localparam logic [4:0] REG_THRESH    = 5'h02;
  localparam logic [4:0] REG_CLAIM     = 5'h03;
  localparam logic [4:0] REG_PRIO_BASE = 5'h10;

  localparam int NSRC_MAX = 16;

  // ID 0 means "no source", so IDs span 0..nsrc
  function automatic int id_width(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_WAIT_CLAIM = 2'd2
  } eip_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a level request as pending, tracks claim/complete handshake.
// Latency: request high before an edge -> pending after that edge.
// Backpressure: a source that stays high is held off while pending or in service.
module plic_gateway
  import plic_lite_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);

  logic r_pending;
  logic r_in_service;

  // Pending/in-service pair: claim moves pending to in-service, complete frees the source
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      if (i_claim) begin
        r_pending <= 1'b0;
      end else if (i_irq && !r_pending && !r_in_service) begin
        r_pending <= 1'b1;
      end

      if (i_claim) begin
        r_in_service <= 1'b1;
      end else if (i_complete) begin
        r_in_service <= 1'b0;
      end
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/plic_lite.sv
// Interrupt arbiter: gateways, enables, priorities and threshold feed a single external interrupt.
// Latency: irq_src -> pending (1 edge) -> best (2 edges) -> eip (3 edges); spo is combinational.
// Backpressure: none; MMIO accesses complete in one cycle, eip masked until the handler claims.
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic [4:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  output logic            eip,
  input  logic            eip_reply
);

  localparam int ID_W = id_width(NSRC);

  logic [NSRC-1:0]   r_enable;
  logic [PRIO_W-1:0] r_threshold;
  logic [PRIO_W-1:0] r_prio [NSRC];
  logic [ID_W-1:0]   r_best_id;
  logic [PRIO_W-1:0] r_best_prio;
  eip_state_t        r_state;
  logic              r_eip;

  logic [NSRC-1:0]   w_pending;
  logic [NSRC-1:0]   w_in_service;
  logic [NSRC-1:0]   w_claim_vec;
  logic [NSRC-1:0]   w_cmpl_vec;
  logic [NSRC-1:0]   w_cand;
  logic [ID_W-1:0]   w_win_id;
  logic [PRIO_W-1:0] w_win_prio;
  logic              w_best_valid;
  logic              w_claim_fire;
  logic [31:0]       w_spo;

  assign w_best_valid = (r_best_id != '0) && (r_best_prio > r_threshold);
  assign w_claim_fire = rd && (a == REG_CLAIM) && w_best_valid;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_gw
    assign w_claim_vec[gi] = w_claim_fire && (r_best_id == ID_W'(gi + 1));
    // Compare the full write word so out-of-range IDs never alias onto a real source
    assign w_cmpl_vec[gi]  = we && (a == REG_CLAIM) && (d == 32'(gi + 1));

    plic_gateway u_gw (
      .clk          (clk),
      .rst          (rst),
      .i_irq        (irq_src[gi]),
      .i_claim      (w_claim_vec[gi]),
      .i_complete   (w_cmpl_vec[gi]),
      .o_pending    (w_pending[gi]),
      .o_in_service (w_in_service[gi])
    );
  end

  // Arbiter: highest priority wins, ascending scan with strict > keeps the lowest ID on ties.
  // The ID being claimed this cycle is masked so best_id never points at it after the claim edge.
  always_comb begin
    w_cand     = w_pending & ~w_claim_vec & r_enable;
    w_win_id   = '0;
    w_win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_cand[i] && (r_prio[i] > w_win_prio)) begin
        w_win_prio = r_prio[i];
        w_win_id   = ID_W'(i + 1);
      end
    end
  end

  // Register the arbitration result every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_id   <= '0;
      r_best_prio <= '0;
    end else begin
      r_best_id   <= w_win_id;
      r_best_prio <= w_win_prio;
    end
  end

  // Software-writable configuration; writes truncate to field width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable    <= '0;
      r_threshold <= '0;
      for (int i = 0; i < NSRC; i++) r_prio[i] <= '0;
    end else if (we) begin
      if (a == REG_ENABLE) r_enable    <= d[NSRC-1:0];
      if (a == REG_THRESH) r_threshold <= d[PRIO_W-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (a == REG_PRIO_BASE + 5'(i)) r_prio[i] <= d[PRIO_W-1:0];
      end
    end
  end

  // eip FSM: raise on a valid winner, drop on acknowledge and hold low until the handler claims
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_eip   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_best_valid) begin
            r_state <= ST_ASSERT;
            r_eip   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (w_claim_fire) begin
            r_state <= ST_IDLE;
            r_eip   <= 1'b0;
          end else if (eip_reply) begin
            r_state <= ST_WAIT_CLAIM;
            r_eip   <= 1'b0;
          end else if (!w_best_valid) begin
            r_state <= ST_IDLE;
            r_eip   <= 1'b0;
          end
        end
        ST_WAIT_CLAIM: begin
          if (w_claim_fire || !w_best_valid) begin
            r_state <= ST_IDLE;
          end
          r_eip <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_eip   <= 1'b0;
        end
      endcase
    end
  end

  // Read mux; unmapped indices return zero
  always_comb begin
    w_spo = '0;
    case (a)
      REG_PENDING: w_spo[NSRC-1:0]   = w_pending;
      REG_ENABLE:  w_spo[NSRC-1:0]   = r_enable;
      REG_THRESH:  w_spo[PRIO_W-1:0] = r_threshold;
      REG_CLAIM:   w_spo[ID_W-1:0]   = w_best_valid ? r_best_id : '0;
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (a == REG_PRIO_BASE + 5'(i)) w_spo[PRIO_W-1:0] = r_prio[i];
        end
      end
    endcase
  end

  assign spo = w_spo;
  assign eip = r_eip;

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: register map, latency, arbitration, eip handshake, reset.
// Latency: checks sampled 1-2 time units after the rising edge.
// Backpressure: n/a.
module tb_plic_lite;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [4:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        eip;
  logic        eip_reply;

  int n_pass;
  int n_total;
  int n_fail;

  plic_lite #(.NSRC(8), .PRIO_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .a         (a),
    .d         (d),
    .we        (we),
    .rd        (rd),
    .spo       (spo),
    .eip       (eip),
    .eip_reply (eip_reply)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    a  = addr;
    d  = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(tag, spo, exp);
  endtask

  // Claim read: sample spo before the edge, rd applies the side effect on that edge
  task automatic claim(input string tag, input logic [31:0] exp);
    a  = 5'h03;
    rd = 1'b1;
    #1;
    chk(tag, spo, exp);
    tick();
    rd = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    clk = 1'b0; rst = 1'b1; irq_src = '0; a = '0; d = '0;
    we = 1'b0; rd = 1'b0; eip_reply = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state and register map
    chk("rst_eip", {31'd0, eip}, 32'd0);
    chk_reg("rst_pending", 5'h00, 32'd0);
    chk_reg("rst_enable", 5'h01, 32'd0);
    chk_reg("rst_thresh", 5'h02, 32'd0);
    chk_reg("rst_claim", 5'h03, 32'd0);
    chk_reg("rst_prio3", 5'h12, 32'd0);
    wr(5'h02, 32'hFFFF_FFFF);
    chk_reg("thresh_trunc", 5'h02, 32'd7);
    wr(5'h02, 32'd0);
    wr(5'h01, 32'hFFFF_FF00);
    chk_reg("enable_trunc", 5'h01, 32'd0);
    wr(5'h08, 32'h1234_5678);
    chk_reg("unmapped_rd", 5'h08, 32'd0);
    wr(5'h18, 32'd5);
    chk_reg("prio_oob_rd", 5'h18, 32'd0);
    wr(5'h17, 32'd6);
    chk_reg("prio8_rw", 5'h17, 32'd6);
    wr(5'h17, 32'd0);

    // 1: single source latency and claim
    wr(5'h12, 32'd5);
    wr(5'h01, 32'h04);
    irq_src = 8'h04;
    tick();
    chk("t1_eip_e0", {31'd0, eip}, 32'd0);
    chk_reg("t1_pend_e0", 5'h00, 32'h04);
    tick();
    chk("t1_eip_e1", {31'd0, eip}, 32'd0);
    tick();
    chk("t1_eip_e2", {31'd0, eip}, 32'd1);
    claim("t1_claim", 32'd3);
    chk("t1_eip_after", {31'd0, eip}, 32'd0);
    chk_reg("t1_pend_after", 5'h00, 32'd0);

    // 5: held source stays quiet while in service; bad completes ignored
    tick(); tick(); tick();
    chk_reg("t5_no_repend", 5'h00, 32'd0);
    wr(5'h03, 32'd0);
    wr(5'h03, 32'd9);
    wr(5'h03, 32'd1);
    wr(5'h03, 32'h0000_0103);
    tick();
    chk_reg("t5_bad_cmpl", 5'h00, 32'd0);
    chk("t5_bad_eip", {31'd0, eip}, 32'd0);
    wr(5'h03, 32'd3);
    chk_reg("t5_cmpl_edge", 5'h00, 32'd0);
    tick();
    chk_reg("t5_repend", 5'h00, 32'h04);
    tick();
    chk("t5_eip_lo", {31'd0, eip}, 32'd0);
    tick();
    chk("t5_eip_hi", {31'd0, eip}, 32'd1);

    // 4: acknowledge masks eip until claim
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;
    chk("t4_ack_drop", {31'd0, eip}, 32'd0);
    tick(); tick();
    chk("t4_wait_lo", {31'd0, eip}, 32'd0);
    eip_reply = 1'b1;
    tick();
    eip_reply = 1'b0;
    tick();
    chk("t4_ack_ignored", {31'd0, eip}, 32'd0);
    claim("t4_claim", 32'd3);
    tick();
    chk("t4_idle_lo", {31'd0, eip}, 32'd0);
    irq_src = 8'h00;
    wr(5'h03, 32'd3);
    irq_src = 8'h04;
    tick(); tick();
    chk("t4_second_lo", {31'd0, eip}, 32'd0);
    tick();
    chk("t4_second_hi", {31'd0, eip}, 32'd1);
    claim("t4_claim2", 32'd3);
    irq_src = 8'h00;
    wr(5'h03, 32'd3);

    // 3: threshold gating
    wr(5'h10, 32'd3);
    wr(5'h01, 32'h01);
    wr(5'h02, 32'd3);
    irq_src = 8'h01;
    tick(); tick(); tick(); tick();
    chk("t3_thr_block", {31'd0, eip}, 32'd0);
    chk_reg("t3_pend", 5'h00, 32'h01);
    claim("t3_claim_inval", 32'd0);
    chk_reg("t3_pend_kept", 5'h00, 32'h01);
    wr(5'h02, 32'd2);
    chk("t3_wr_edge", {31'd0, eip}, 32'd0);
    tick();
    chk("t3_eip_rise", {31'd0, eip}, 32'd1);
    claim("t3_claim", 32'd1);
    irq_src = 8'h00;
    wr(5'h03, 32'd1);
    wr(5'h02, 32'd0);

    // 2: priority order with tie broken by lowest ID
    wr(5'h11, 32'd4);
    wr(5'h14, 32'd4);
    wr(5'h15, 32'd2);
    wr(5'h01, 32'h32);
    irq_src = 8'h32;
    tick(); tick(); tick();
    chk("t2_eip", {31'd0, eip}, 32'd1);
    claim("t2_claim2", 32'd2);
    chk_reg("t2_pend", 5'h00, 32'h30);
    irq_src = 8'h30;
    wr(5'h03, 32'd2);
    chk("t2_eip_again", {31'd0, eip}, 32'd1);
    claim("t2_claim5", 32'd5);
    irq_src = 8'h20;
    wr(5'h03, 32'd5);
    claim("t2_claim6", 32'd6);
    irq_src = 8'h00;
    wr(5'h03, 32'd6);
    chk_reg("t2_pend_empty", 5'h00, 32'd0);
    claim("t2_claim_none", 32'd0);

    // 6: reset while eip high and a source in service
    wr(5'h01, 32'h24);
    wr(5'h02, 32'd1);
    irq_src = 8'h04;
    tick(); tick(); tick();
    chk("t6_eip_a", {31'd0, eip}, 32'd1);
    claim("t6_claim3", 32'd3);
    irq_src = 8'h24;
    tick(); tick(); tick();
    chk("t6_eip_b", {31'd0, eip}, 32'd1);
    rst = 1'b1;
    tick();
    irq_src = 8'h00;
    chk("t6_rst_eip", {31'd0, eip}, 32'd0);
    chk_reg("t6_rst_pend", 5'h00, 32'd0);
    chk_reg("t6_rst_en", 5'h01, 32'd0);
    chk_reg("t6_rst_thr", 5'h02, 32'd0);
    chk_reg("t6_rst_prio", 5'h12, 32'd0);
    chk_reg("t6_rst_claim", 5'h03, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_eip", {31'd0, eip}, 32'd0);
    // in_service for ID3 must be gone: a fresh request flows straight through
    wr(5'h12, 32'd5);
    wr(5'h01, 32'h04);
    irq_src = 8'h04;
    tick(); tick(); tick();
    chk("t6_fresh_eip", {31'd0, eip}, 32'd1);
    claim("t6_fresh_claim", 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
